// File: rtl/pong_match_ctrl.sv
// Match sequencer for the pong ball datapath: game state, serve timing, rally speed and scores.
// Optional feature: define PONG_AUTO_RESTART_EN to restart a finished match automatically while start is held.
module pong_match_ctrl #(
    parameter int unsigned WIN_SCORE = 3,
    parameter int unsigned SERVE_DLY = 25_000_000,
    parameter int unsigned HITS_FAST = 4,
    parameter int unsigned CNT_W     = 26
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       paddle_hit,
    input  logic       point_left,
    input  logic       point_right,
    output logic       ball_run,
    output logic       fast_mode,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SERVE = 3'd1;
    localparam logic [2:0] RALLY = 3'd2;
    localparam logic [2:0] POINT = 3'd3;
    localparam logic [2:0] OVER  = 3'd4;

    localparam int unsigned    HIT_W    = (HITS_FAST < 2) ? 1 : $clog2(HITS_FAST + 1);
    localparam logic [HIT_W-1:0] HIT_MAX  = HIT_W'(HITS_FAST);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(SERVE_DLY - 1);
    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

    logic             start_q;
    logic             start_rise;
    logic [CNT_W-1:0] dly_cnt;
    logic [HIT_W-1:0] hit_cnt;

    logic [2:0]       nxt_state;
    logic [CNT_W-1:0] nxt_cnt;
    logic [HIT_W-1:0] nxt_hit;
    logic             nxt_fast;
    logic [3:0]       nxt_sl;
    logic [3:0]       nxt_sr;
    logic             nxt_over;
    logic [1:0]       nxt_win;
    logic             new_match;
`ifdef PONG_AUTO_RESTART_EN
    logic [1:0]       lap_cnt;
    logic [1:0]       nxt_lap;
`endif

    assign start_rise = start & ~start_q;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = dly_cnt;
        nxt_hit   = hit_cnt;
        nxt_fast  = fast_mode;
        nxt_sl    = score_l;
        nxt_sr    = score_r;
        nxt_over  = game_over;
        nxt_win   = winner;
        new_match = 1'b0;
`ifdef PONG_AUTO_RESTART_EN
        nxt_lap   = lap_cnt;
`endif
        case (state)
            IDLE: begin
                if (start_rise) begin
                    new_match = 1'b1;
                end
            end
            SERVE: begin
                if (!start) begin
                    nxt_state = IDLE;
                end else if (dly_cnt == DLY_LAST) begin
                    nxt_state = RALLY;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt = dly_cnt + CNT_W'(1);
                end
            end
            RALLY: begin
                if (!start) begin
                    nxt_state = IDLE;
                end else if (point_left && point_right) begin
                    nxt_state = SERVE;
                    nxt_cnt   = '0;
                    nxt_hit   = '0;
                    nxt_fast  = 1'b0;
                end else if (point_left) begin
                    nxt_sr    = score_r + 4'd1;
                    nxt_state = POINT;
                end else if (point_right) begin
                    nxt_sl    = score_l + 4'd1;
                    nxt_state = POINT;
                end else begin
                    // fast_mode trails the hit count by one cycle
                    nxt_fast = (hit_cnt == HIT_MAX);
                    if (paddle_hit && (hit_cnt != HIT_MAX)) begin
                        nxt_hit = hit_cnt + HIT_W'(1);
                    end
                end
            end
            POINT: begin
                nxt_hit  = '0;
                nxt_fast = 1'b0;
                nxt_cnt  = '0;
`ifdef PONG_AUTO_RESTART_EN
                nxt_lap  = '0;
`endif
                if (!start) begin
                    nxt_state = IDLE;
                end else if (score_l == WIN) begin
                    nxt_win   = 2'b01;
                    nxt_over  = 1'b1;
                    nxt_state = OVER;
                end else if (score_r == WIN) begin
                    nxt_win   = 2'b10;
                    nxt_over  = 1'b1;
                    nxt_state = OVER;
                end else begin
                    nxt_state = SERVE;
                end
            end
            OVER: begin
                if (start_rise) begin
                    new_match = 1'b1;
                end else if (!start) begin
                    nxt_state = IDLE;
`ifdef PONG_AUTO_RESTART_EN
                // 4*SERVE_DLY is counted as four laps of the serve counter so it fits in CNT_W bits
                end else if (dly_cnt == DLY_LAST) begin
                    nxt_cnt = '0;
                    if (lap_cnt == 2'd3) begin
                        new_match = 1'b1;
                    end else begin
                        nxt_lap = lap_cnt + 2'd1;
                    end
                end else begin
                    nxt_cnt = dly_cnt + CNT_W'(1);
`endif
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        if (new_match) begin
            nxt_state = SERVE;
            nxt_cnt   = '0;
            nxt_hit   = '0;
            nxt_fast  = 1'b0;
            nxt_sl    = '0;
            nxt_sr    = '0;
            nxt_over  = 1'b0;
            nxt_win   = '0;
`ifdef PONG_AUTO_RESTART_EN
            nxt_lap   = '0;
`endif
        end

        if (nxt_state == IDLE) begin
            nxt_cnt  = '0;
            nxt_hit  = '0;
            nxt_fast = 1'b0;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            start_q   <= 1'b0;
            state     <= IDLE;
            dly_cnt   <= '0;
            hit_cnt   <= '0;
            ball_run  <= 1'b0;
            fast_mode <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
            game_over <= 1'b0;
            winner    <= '0;
`ifdef PONG_AUTO_RESTART_EN
            lap_cnt   <= '0;
`endif
        end else begin
            start_q   <= start;
            state     <= nxt_state;
            dly_cnt   <= nxt_cnt;
            hit_cnt   <= nxt_hit;
            ball_run  <= (nxt_state == RALLY);
            fast_mode <= nxt_fast;
            score_l   <= nxt_sl;
            score_r   <= nxt_sr;
            game_over <= nxt_over;
            winner    <= nxt_win;
`ifdef PONG_AUTO_RESTART_EN
            lap_cnt   <= nxt_lap;
`endif
        end
    end

endmodule
